// File: rtl/bus_rr_arbiter.sv
// ============================================================================
//  Module   : bus_rr_arbiter
//  Purpose  : Round-robin arbiter of N cache requesters onto one memory port,
//             running whole-block read/write bursts. Optional snoop outputs
//             are enabled by defining BUS_SNOOP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_rr_arbiter #(
  parameter int num_caches_p     = 4,
  parameter int block_width_p    = 8,
  parameter int dma_data_width_p = 2,
  localparam int beats_lp = block_width_p / dma_data_width_p,
  localparam int pkt_w_lp = 1 + 32 + dma_data_width_p * 32,
  localparam int C_OWN_W  = (num_caches_p > 1) ? $clog2(num_caches_p) : 1
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [num_caches_p-1:0]            cb_valid_i,
  input  logic [num_caches_p*pkt_w_lp-1:0]   cb_pkt_i,
  output logic [num_caches_p-1:0]            cb_yumi_o,
  output logic [num_caches_p-1:0]            cb_valid_o,
  output logic [dma_data_width_p*32-1:0]     cb_data_o,
  input  logic                               mem_ready_i,
  output logic                               mem_valid_o,
  output logic                               mem_we_o,
  output logic [31:0]                        mem_addr_o,
  output logic [dma_data_width_p*32-1:0]     mem_wdata_o,
  input  logic                               mem_valid_i,
  input  logic [dma_data_width_p*32-1:0]     mem_data_i,
  output logic                               busy_o,
  output logic [C_OWN_W-1:0]                 owner_o
`ifdef BUS_SNOOP_EN
  ,
  output logic                               snoop_valid_o,
  output logic [31:0]                        snoop_addr_o,
  output logic                               snoop_we_o,
  output logic [num_caches_p-1:0]            snoop_mask_o
`endif
);

  localparam int          C_DW         = dma_data_width_p * 32;
  localparam int          C_ALIGN      = $clog2(block_width_p * 4);
  localparam int          C_BEAT_W     = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam logic [31:0] C_ALIGN_MASK = ~((32'd1 << C_ALIGN) - 32'd1);
  localparam logic [31:0] C_BEAT_BYTES = 32'(dma_data_width_p * 4);
  localparam logic [C_BEAT_W-1:0] C_LAST_BEAT = C_BEAT_W'(beats_lp - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WR_BURST = 2'd1,
    S_RD_WAIT  = 2'd2
  } state_t;

  state_t              r_state,  w_state_nxt;
  logic [C_OWN_W-1:0]  r_rr,     w_rr_nxt;
  logic [C_OWN_W-1:0]  r_owner,  w_owner_nxt;
  logic [31:0]         r_base,   w_base_nxt;
  logic [C_BEAT_W-1:0] r_beat,   w_beat_nxt;
  logic [C_BEAT_W-1:0] r_rd_cnt, w_rd_cnt_nxt;

  logic                w_any;
  logic [C_OWN_W-1:0]  w_win;
  logic [pkt_w_lp-1:0] w_win_pkt;
  logic                w_win_we;
  logic [31:0]         w_win_base;
  logic [C_DW-1:0]     w_win_wdata;
  logic [C_DW-1:0]     w_own_wdata;

  // Scan downward so the requester closest to r_rr is the last (winning) hit.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = num_caches_p - 1; i >= 0; i--) begin
      if (cb_valid_i[(int'(r_rr) + i) % num_caches_p]) begin
        w_any = 1'b1;
        w_win = C_OWN_W'((int'(r_rr) + i) % num_caches_p);
      end
    end
  end

  always_comb begin
    w_win_pkt   = cb_pkt_i[int'(w_win) * pkt_w_lp +: pkt_w_lp];
    w_win_we    = w_win_pkt[pkt_w_lp-1];
    w_win_base  = w_win_pkt[pkt_w_lp-2 -: 32] & C_ALIGN_MASK;
    w_win_wdata = w_win_pkt[C_DW-1:0];
    w_own_wdata = cb_pkt_i[int'(r_owner) * pkt_w_lp +: C_DW];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= S_IDLE;
      r_rr     <= '0;
      r_owner  <= '0;
      r_base   <= '0;
      r_beat   <= '0;
      r_rd_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr     <= w_rr_nxt;
      r_owner  <= w_owner_nxt;
      r_base   <= w_base_nxt;
      r_beat   <= w_beat_nxt;
      r_rd_cnt <= w_rd_cnt_nxt;
    end
  end

  // Handshake outputs are suppressed during reset so an aborted burst emits nothing.
  always_comb begin
    w_state_nxt  = r_state;
    w_rr_nxt     = r_rr;
    w_owner_nxt  = r_owner;
    w_base_nxt   = r_base;
    w_beat_nxt   = r_beat;
    w_rd_cnt_nxt = r_rd_cnt;
    cb_yumi_o    = '0;
    cb_valid_o   = '0;
    mem_valid_o  = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
`ifdef BUS_SNOOP_EN
    snoop_valid_o = 1'b0;
    snoop_addr_o  = '0;
    snoop_we_o    = 1'b0;
    snoop_mask_o  = '0;
`endif
    if (!reset_i) begin
      case (r_state)
        S_IDLE: begin
          if (w_any && mem_ready_i) begin
            cb_yumi_o[w_win] = 1'b1;
            mem_valid_o      = 1'b1;
            mem_we_o         = w_win_we;
            mem_addr_o       = w_win_base;
            mem_wdata_o      = w_win_wdata;
            w_owner_nxt      = w_win;
            w_base_nxt       = w_win_base;
            w_rr_nxt         = C_OWN_W'((int'(w_win) + 1) % num_caches_p);
            w_rd_cnt_nxt     = '0;
            if (!w_win_we) begin
              w_state_nxt = S_RD_WAIT;
              w_beat_nxt  = '0;
            end else if (beats_lp > 1) begin
              w_state_nxt = S_WR_BURST;
              w_beat_nxt  = C_BEAT_W'(1);
            end else begin
              w_beat_nxt  = '0;
            end
`ifdef BUS_SNOOP_EN
            snoop_valid_o        = 1'b1;
            snoop_addr_o         = w_win_base;
            snoop_we_o           = w_win_we;
            snoop_mask_o         = '1;
            snoop_mask_o[w_win]  = 1'b0;
`endif
          end
        end
        S_WR_BURST: begin
          if (cb_valid_i[r_owner] && mem_ready_i) begin
            cb_yumi_o[r_owner] = 1'b1;
            mem_valid_o        = 1'b1;
            mem_we_o           = 1'b1;
            mem_addr_o         = r_base + C_BEAT_BYTES * 32'(r_beat);
            mem_wdata_o        = w_own_wdata;
            if (r_beat == C_LAST_BEAT) begin
              w_beat_nxt  = '0;
              w_state_nxt = S_IDLE;
            end else begin
              w_beat_nxt  = r_beat + C_BEAT_W'(1);
            end
          end
        end
        S_RD_WAIT: begin
          if (mem_valid_i) begin
            cb_valid_o[r_owner] = 1'b1;
            if (r_rd_cnt == C_LAST_BEAT) begin
              w_rd_cnt_nxt = '0;
              w_state_nxt  = S_IDLE;
            end else begin
              w_rd_cnt_nxt = r_rd_cnt + C_BEAT_W'(1);
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign cb_data_o = mem_data_i;
  assign busy_o    = (r_state != S_IDLE);
  assign owner_o   = r_owner;

endmodule

`default_nettype wire
